fn_menor_serie: RTL
===================

// Module: fn_menor_serie
// PURPOSE
//  Multi-cycle *LESS THAN* comparator for 32-bit operands, signed (two's complement) or unsigned.
//  Scans the operands MSB-first, BITS_POR_CICLO bits per clock, under a start/done handshake.
//  Serves the area-reduced RV32I datapath variant (SLT/SLTU/BLT/BGE/BLTU/BGEU) in place of the
//  single-cycle comparator.
//  Also reports equality, so the branch unit can form BEQ/BNE/BGE from the same run.
// PARAMETERS
//  ANCHO           32  operand width in bits
//  BITS_POR_CICLO  1   bits examined per clock; must divide ANCHO (legal values: 1,2,4,8,16,32)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  inicio     in   1      start request; sampled only while ocupado=0
//  a          in   ANCHO  operand A; captured on the accepting edge
//  b          in   ANCHO  operand B; captured on the accepting edge
//  sin_signo  in   1      0 = signed compare, 1 = unsigned; captured on the accepting edge
//  ocupado    out  1      high while a comparison is in progress
//  listo      out  1      one-cycle pulse: menor/igual valid
//  menor      out  1      1 when A < B under the captured signedness
//  igual      out  1      1 when A == B
// BEHAVIOUR
//  Reset and clocking
//  - Synchronous active-high rst: on any edge with rst=1, FSM->REPOSO and ocupado=listo=menor=igual=0.
//  - rst has priority over inicio and wins even mid-comparison; the run is discarded with no listo.
//  States
//  - REPOSO: ocupado=0.
//    inicio=1 at an edge -> capture a, b, sin_signo; clear decided flag; idx=0; go to COMPARA.
//  - COMPARA: ocupado=1; inicio is ignored.
//    Each edge examines chunk idx, bits [ANCHO-1-idx*BPC -: BPC]. Chunks are compared unsigned,
//    except the MSB of chunk 0 when sin_signo=0: it carries negative weight
//    (a_msb=1,b_msb=0 -> A<B; a_msb=0,b_msb=1 -> A>B).
//    First unequal chunk sets decided=1 and latches menor_int; later chunks do not change it.
//  - Constant time, no early exit: exactly N = ANCHO/BITS_POR_CICLO edges are spent in COMPARA.
//  - At edge N (counting the accepting edge as 0): menor <= menor_int, igual <= ~decided,
//    listo <= 1, ocupado <= 0, FSM -> REPOSO.
//  Timing and outputs
//  - Latency = N cycles from the accepting edge to listo (32 for defaults, 1 for BPC=32).
//  - listo is high for exactly one cycle.
//  - menor/igual hold their value until the next listo or rst.
//  - Back-to-back runs: inicio=1 during the listo cycle is accepted (ocupado=0), so there is no
//    dead cycle between runs.
//  - Operand inputs may change freely after the accepting edge; only captured copies are used.
//  - igual=1 forces menor=0.
// STRUCTURE
//  - Shared include rv32i_defs.vh: state encodings (ST_REPOSO, ST_COMPARA); SIGNO_CON=1'b0 and
//    SIGNO_SIN=1'b1 select constants shared with the ALU decoder.
//  - One sub-module, cmp_tramo: a combinational BPC-bit chunk comparator.
//    Inputs: x, y, msb_negativo. Outputs: lt, ne.
//  - Top level holds the FSM, chunk index counter (clog2(N) bits), operand shift registers,
//    and the decided/menor_int flags.
// TESTING
//  - Reset mid-run: start a=1,b=2; assert rst at cycle 10 -> ocupado=0, no listo, menor=igual=0.
//  - Unsigned: a=32'h0000_0001, b=32'hFFFF_FFFF, sin_signo=1 -> listo at cycle 32, menor=1, igual=0.
//    Same operands with sin_signo=0 -> menor=0, igual=0.
//  - Signed negatives: a=32'h8000_0000, b=32'h7FFF_FFFF, sin_signo=0 -> menor=1.
//    Also a=32'hFFFF_FFFE (-2), b=32'hFFFF_FFFF (-1) -> menor=1.
//  - Equality: a=b=32'hDEAD_BEEF, both signedness values -> menor=0, igual=1.
//    Latency is 32 cycles in every case (no early exit).
//  - Handshake: inicio held high through a run -> only one accept.
//    Second run with a=5,b=3 accepted in the listo cycle -> listo again 32 cycles later, menor=0.
//    Inputs changed after accept are ignored.
//  - Parameter sweep: BPC in {1,4,32}, 10k random a/b/sin_signo.
//    Compare against ($signed(a)<$signed(b)) or (a<b), and against a==b.
//    Latency must be exactly 32/BPC.

Source files
------------

// File: rtl/fn_menor_serie_pkg.sv
// Shared types and select constants for the serial less-than comparator.
package fn_menor_serie_pkg;

  typedef enum logic {
    ST_REPOSO  = 1'b0,
    ST_COMPARA = 1'b1
  } estado_t;

  // Signedness select values shared with the ALU decoder.
  localparam logic SIGNO_CON = 1'b0;
  localparam logic SIGNO_SIN = 1'b1;

endpackage

// File: rtl/fn_menor_serie_if.sv
// Start/done bus of the serial comparator, plus the FSM state for observation.
interface fn_menor_serie_if #(
  parameter int ANCHO = 32
);
  import fn_menor_serie_pkg::*;

  // inicio is accepted on an edge where ocupado=0; listo pulses one cycle when
  // menor/igual become valid, and they hold until the next listo or reset.
  logic             inicio;
  logic [ANCHO-1:0] a;
  logic [ANCHO-1:0] b;
  logic             sin_signo;
  logic             ocupado;
  logic             listo;
  logic             menor;
  logic             igual;
  estado_t          estado;

  modport master (
    output inicio, a, b, sin_signo,
    input  ocupado, listo, menor, igual, estado
  );

  modport slave (
    input  inicio, a, b, sin_signo,
    output ocupado, listo, menor, igual, estado
  );

endinterface

// File: rtl/fn_menor_serie_cmp_tramo.sv
// Combinational chunk comparator; the chunk MSB may carry negative weight.
module fn_menor_serie_cmp_tramo #(
  parameter int BPC = 1
) (
  input  logic [BPC-1:0] x,
  input  logic [BPC-1:0] y,
  input  logic           msb_negativo,
  output logic           lt,
  output logic           ne
);

  always_comb begin
    ne = (x != y);
    // Differing sign bits decide on their own; otherwise unsigned order holds.
    if (msb_negativo && (x[BPC-1] != y[BPC-1])) begin
      lt = x[BPC-1];
    end else begin
      lt = (x < y);
    end
  end

endmodule

// File: rtl/fn_menor_serie.sv
// Constant-time MSB-first less-than/equal comparator, BITS_POR_CICLO bits per clock.
module fn_menor_serie
  import fn_menor_serie_pkg::*;
#(
  parameter int ANCHO          = 32,
  parameter int BITS_POR_CICLO = 1
) (
  input  logic               clk,
  input  logic               rst,
  fn_menor_serie_if.slave    bus
);

  localparam int N  = ANCHO / BITS_POR_CICLO;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] ULTIMO = IW'(N - 1);

  estado_t          estado, estado_sig;
  logic             acepta, termina;
  logic [IW-1:0]    idx;
  logic [ANCHO-1:0] a_q, b_q;
  logic             sin_q;
  logic             decidido, menor_int;
  logic             listo_q, menor_q, igual_q;
  logic             tramo_lt, tramo_ne, msb_neg;

  assign msb_neg = (idx == '0) && (sin_q == SIGNO_CON);

  fn_menor_serie_cmp_tramo #(.BPC(BITS_POR_CICLO)) u_tramo (
    .x            (a_q[ANCHO-1 -: BITS_POR_CICLO]),
    .y            (b_q[ANCHO-1 -: BITS_POR_CICLO]),
    .msb_negativo (msb_neg),
    .lt           (tramo_lt),
    .ne           (tramo_ne)
  );

  always_ff @(posedge clk) begin
    if (rst) estado <= ST_REPOSO;
    else     estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    acepta     = 1'b0;
    termina    = 1'b0;
    case (estado)
      ST_REPOSO: begin
        if (bus.inicio) begin
          acepta     = 1'b1;
          estado_sig = ST_COMPARA;
        end
      end
      ST_COMPARA: begin
        if (idx == ULTIMO) begin
          termina    = 1'b1;
          estado_sig = ST_REPOSO;
        end
      end
      default: estado_sig = ST_REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sin_q     <= 1'b0;
      decidido  <= 1'b0;
      menor_int <= 1'b0;
      listo_q   <= 1'b0;
      menor_q   <= 1'b0;
      igual_q   <= 1'b0;
    end else begin
      listo_q <= 1'b0;
      if (acepta) begin
        a_q       <= bus.a;
        b_q       <= bus.b;
        sin_q     <= bus.sin_signo;
        idx       <= '0;
        decidido  <= 1'b0;
        menor_int <= 1'b0;
      end else if (estado == ST_COMPARA) begin
        a_q <= a_q << BITS_POR_CICLO;
        b_q <= b_q << BITS_POR_CICLO;
        idx <= idx + 1'b1;
        if (!decidido && tramo_ne) begin
          decidido  <= 1'b1;
          menor_int <= tramo_lt;
        end
        // The final chunk is folded in on the same edge that publishes the result.
        if (termina) begin
          listo_q <= 1'b1;
          menor_q <= decidido ? menor_int : tramo_lt;
          igual_q <= ~(decidido | tramo_ne);
        end
      end
    end
  end

  assign bus.ocupado = (estado == ST_COMPARA);
  assign bus.listo   = listo_q;
  assign bus.menor   = menor_q;
  assign bus.igual   = igual_q;
  assign bus.estado  = estado;

endmodule
